// File: rtl/RSA_pkg.sv
// Shared types for the RSA exponentiation block: host control/status byte,
// loader FSM states and operand selection.
package RSA_pkg;

    localparam int HOST_WORD = 32;

    typedef struct packed {
        logic [1:0] nu_7_6;
        logic       ready;
        logic       read_u;
        logic       load_n;
        logic       load_e;
        logic       load_x;
        logic       start;
    } control_reg_type;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        BUSY,
        UNLOAD
    } loader_state_t;

    typedef enum logic [1:0] {
        SEL_N,
        SEL_E,
        SEL_X
    } operand_sel_t;

    // Position of an operand inside the {n,e,x} flag vector.
    function automatic logic [2:0] sel_mask(input operand_sel_t sel);
        case (sel)
            SEL_N:   return 3'b100;
            SEL_E:   return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/rsa_word_shifter.sv
// NBITS register built from WORD-wide lanes: parallel load, or shift one word
// towards the LSW with a new word entering at the top.
module rsa_word_shifter #(
    parameter int NBITS = 1024,
    parameter int WORD  = 32
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [NBITS-1:0] load_data,
    input  logic             shift_en,
    input  logic [WORD-1:0]  shift_in,
    output logic [NBITS-1:0] q
);

    localparam int NWORDS = NBITS / WORD;

    logic [NBITS-1:0] q_reg;
    logic [NBITS-1:0] q_next;

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_lane
            logic [WORD-1:0] upper_word;

            if (gi == NWORDS - 1) begin : g_top
                assign upper_word = shift_in;
            end else begin : g_mid
                assign upper_word = q_reg[(gi+1)*WORD +: WORD];
            end

            // Parallel load wins over shifting.
            assign q_next[gi*WORD +: WORD] =
                load_en  ? load_data[gi*WORD +: WORD] :
                shift_en ? upper_word :
                           q_reg[gi*WORD +: WORD];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/rsa_host_loader.sv
// Word-serial host front end for the RSA core: decodes command edges, loads
// n/e/x LSW-first, starts the core and streams the result u back.
module rsa_host_loader
    import RSA_pkg::*;
#(
    parameter int NBITS = 1024,
    parameter int WORD  = HOST_WORD
)(
    input  logic             clk,
    input  logic             rst_n,
    input  control_reg_type  ctrl,
    input  logic             wr_valid,
    input  logic [WORD-1:0]  wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [WORD-1:0]  rd_data,
    input  logic             rd_ready,
    output logic [NBITS-1:0] n_out,
    output logic [NBITS-1:0] e_out,
    output logic [NBITS-1:0] x_out,
    output logic [1:0]       nu_out,
    output logic             core_start,
    input  logic             core_done,
    input  logic [NBITS-1:0] u_in,
    output control_reg_type  status,
    output logic [2:0]       loaded,
    output logic             cmd_err
);

    localparam int NWORDS = NBITS / WORD;
    localparam int CNT_W  = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

    control_reg_type ctrl_reg;
    logic [4:0]      cmd_prev_reg;
    logic [4:0]      cmd_edge;

    loader_state_t    state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    operand_sel_t     sel_reg,     sel_next;
    logic [2:0]       loaded_reg,  loaded_next;
    logic             ready_reg,   ready_next;
    logic [1:0]       nu_reg,      nu_next;
    logic             cmd_err_reg, cmd_err_next;

    logic [2:0]       op_shift_en;
    logic             u_load_en;
    logic             u_shift_en;
    logic [NBITS-1:0] op_q [3];
    logic [NBITS-1:0] u_q;

    // The ready bit is a status-only field; the host's copy carries no command.
    logic unused_ctrl_ready;
    assign unused_ctrl_ready = ctrl_reg.ready;

    // Edges come from the registered copy so every command sees a full cycle
    // of settled ctrl before it is acted on.
    assign cmd_edge = ctrl_reg[4:0] & ~cmd_prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg     <= '0;
            cmd_prev_reg <= '0;
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            sel_reg      <= SEL_N;
            loaded_reg   <= '0;
            ready_reg    <= 1'b0;
            nu_reg       <= '0;
            cmd_err_reg  <= 1'b0;
        end else begin
            ctrl_reg     <= ctrl;
            cmd_prev_reg <= ctrl_reg[4:0];
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            sel_reg      <= sel_next;
            loaded_reg   <= loaded_next;
            ready_reg    <= ready_next;
            nu_reg       <= nu_next;
            cmd_err_reg  <= cmd_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        sel_next     = sel_reg;
        loaded_next  = loaded_reg;
        ready_next   = ready_reg;
        nu_next      = nu_reg;
        cmd_err_next = 1'b0;
        op_shift_en  = '0;
        u_load_en    = 1'b0;
        u_shift_en   = 1'b0;

        case (state_reg)
            IDLE: begin
                // Priority chain: lower-priority edges in the same cycle are dropped.
                if (cmd_edge[4]) begin
                    if (ready_reg) begin
                        state_next = UNLOAD;
                        cnt_next   = '0;
                    end else begin
                        cmd_err_next = 1'b1;
                    end
                end else if (cmd_edge[3]) begin
                    state_next  = LOAD;
                    sel_next    = SEL_N;
                    cnt_next    = '0;
                    loaded_next = loaded_reg & ~sel_mask(SEL_N);
                end else if (cmd_edge[2]) begin
                    state_next  = LOAD;
                    sel_next    = SEL_E;
                    cnt_next    = '0;
                    loaded_next = loaded_reg & ~sel_mask(SEL_E);
                end else if (cmd_edge[1]) begin
                    state_next  = LOAD;
                    sel_next    = SEL_X;
                    cnt_next    = '0;
                    loaded_next = loaded_reg & ~sel_mask(SEL_X);
                end else if (cmd_edge[0]) begin
                    if (loaded_reg == 3'b111) begin
                        state_next = START;
                        nu_next    = ctrl_reg.nu_7_6;
                        ready_next = 1'b0;
                    end else begin
                        cmd_err_next = 1'b1;
                    end
                end
            end

            LOAD: begin
                if (wr_valid) begin
                    op_shift_en = sel_mask(sel_reg);
                    cnt_next    = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_WORD) begin
                        loaded_next = loaded_reg | sel_mask(sel_reg);
                        state_next  = IDLE;
                    end
                end
            end

            START: begin
                state_next = BUSY;
            end

            BUSY: begin
                if (core_done) begin
                    u_load_en  = 1'b1;
                    ready_next = 1'b1;
                    state_next = IDLE;
                end
            end

            UNLOAD: begin
                if (rd_ready) begin
                    u_shift_en = 1'b1;
                    cnt_next   = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_WORD) begin
                        ready_next = 1'b0;
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand registers: index 0/1/2 = n/e/x, flag bit 2/1/0 respectively.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_operand
            rsa_word_shifter #(
                .NBITS (NBITS),
                .WORD  (WORD)
            ) u_op_shifter (
                .clk       (clk),
                .rst_n     (rst_n),
                .load_en   (1'b0),
                .load_data ({NBITS{1'b0}}),
                .shift_en  (op_shift_en[2-gi]),
                .shift_in  (wr_data),
                .q         (op_q[gi])
            );
        end
    endgenerate

    rsa_word_shifter #(
        .NBITS (NBITS),
        .WORD  (WORD)
    ) u_result_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (u_load_en),
        .load_data (u_in),
        .shift_en  (u_shift_en),
        .shift_in  ({WORD{1'b0}}),
        .q         (u_q)
    );

    assign n_out      = op_q[0];
    assign e_out      = op_q[1];
    assign x_out      = op_q[2];
    assign nu_out     = nu_reg;
    assign loaded     = loaded_reg;
    assign cmd_err    = cmd_err_reg;
    assign wr_ready   = (state_reg == LOAD);
    assign rd_valid   = (state_reg == UNLOAD);
    assign core_start = (state_reg == START);
    assign rd_data    = u_q[WORD-1:0];

    always_comb begin
        status        = '0;
        status.nu_7_6 = nu_reg;
        status.ready  = ready_reg;
    end

endmodule
